// File: rtl/xg_mem_arbiter.sv
// ============================================================================
//  Module      : xg_mem_arbiter
//  Description : Shares one single-port unified memory between an instruction
//                fetch port and a data load/store port, one transaction at a
//                time. Conflicts go to data (fixed priority) by default, or
//                alternate between ports when XG_MEM_ARB_RR_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xg_mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  // instruction fetch port
  input  logic        ireq,
  input  logic [31:0] iaddr,
  output logic        ivalid,
  output logic [31:0] irdata,
  // data port
  input  logic        dreq,
  input  logic        dwe,
  input  logic [3:0]  damp,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  output logic        dvalid,
  output logic [31:0] drdata,
  // unified memory port
  output logic        mreq,
  output logic        mwe,
  output logic [3:0]  mamp,
  output logic [31:0] maddr,
  output logic [31:0] mwdata,
  input  logic [31:0] mrdata,
  input  logic        mready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;
  logic   owner_data;   // 1 when the transaction in flight belongs to data
  logic   pick_data;    // conflict resolution result, valid in IDLE
  logic   grant_i;
  logic   grant_d;
  logic   busy;

`ifdef XG_MEM_ARB_RR_EN
  // 1 = last grant went to data, 0 = fetch
  logic last_grant;

  // Remember which port won most recently so a conflict goes to the other one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b0;
    end else if (grant_i || grant_d) begin
      last_grant <= grant_d;
    end
  end

  assign pick_data = dreq && (!ireq || !last_grant);
`else
  assign pick_data = dreq;
`endif

  assign busy   = (state == IBUSY) || (state == DBUSY);
  // Combinational from state so an asynchronous reset drops them at once
  assign mreq   = busy;
  assign ivalid = (state == DONE) && !owner_data;
  assign dvalid = (state == DONE) &&  owner_data;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and grant decode; requests are level-sensitive so anything
  // raised outside IDLE simply waits here until the arbiter returns
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_data) begin
          grant_d    = 1'b1;
          state_next = DBUSY;
        end else if (ireq) begin
          grant_i    = 1'b1;
          state_next = IBUSY;
        end
      end
      IBUSY:   if (mready) state_next = DONE;
      DBUSY:   if (mready) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latches toward memory and read-data capture per owning port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_data <= 1'b0;
      maddr      <= 32'd0;
      mwe        <= 1'b0;
      mamp       <= 4'b0000;
      mwdata     <= 32'd0;
      irdata     <= 32'd0;
      drdata     <= 32'd0;
    end else begin
      if (grant_d) begin
        owner_data <= 1'b1;
        maddr      <= daddr;
        mwe        <= dwe;
        mamp       <= damp;
        mwdata     <= dwdata;
      end else if (grant_i) begin
        owner_data <= 1'b0;
        maddr      <= iaddr;
        mwe        <= 1'b0;
        mamp       <= 4'b1111;
        mwdata     <= 32'd0;
      end
      if (mready && (state == IBUSY)) irdata <= mrdata;
      // writes capture too; the returned word is don't-care for the requester
      if (mready && (state == DBUSY)) drdata <= mrdata;
    end
  end

endmodule

`default_nettype wire

// File: doc/xg_mem_arbiter.md
XG_MEM_ARBITER -- requirements
Module: xg_mem_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit; reset is asynchronous and active-high.
REQ-003 SHALL have fetch ports: ireq in 1, iaddr in 32, ivalid out 1, irdata out 32 (instruction read).
REQ-004 SHALL have data ports: dreq in 1, dwe in 1, damp in 4 (byte mask), daddr in 32, dwdata in 32, dvalid out 1, drdata out 32.
REQ-005 SHALL have memory ports: mreq out 1, mwe out 1, mamp out 4, maddr out 32, mwdata out 32, mrdata in 32, mready in 1.

Function
REQ-006 SHALL share one single-port unified memory between the fetch port and the data port, one transaction at a time.
REQ-007 SHALL implement states IDLE, IBUSY, DBUSY and DONE.
REQ-008 In IDLE, if only ireq=1, SHALL latch iaddr, mwe=0 and mamp=4'b1111, then go to IBUSY.
REQ-009 In IDLE, if only dreq=1, SHALL latch daddr, dwe, damp and dwdata, then go to DBUSY.
REQ-010 In IDLE, if both requests are high, SHALL choose the winner per REQ-022/REQ-023.
REQ-011 In IDLE with no request, SHALL remain in IDLE.
REQ-012 In IBUSY/DBUSY, SHALL hold mreq=1 and drive maddr/mwe/mamp/mwdata from the latched registers, stable until mready.
REQ-013 mready is sampled only while mreq=1; mready may be high in the first mreq cycle.
REQ-014 On mready=1 in IBUSY/DBUSY, SHALL capture mrdata into the owning port's rdata register and go to DONE.
REQ-015 In DONE, SHALL pulse ivalid or dvalid (owning port only) for exactly one cycle, with mreq=0; next state is IDLE.
REQ-016 A requester holds req and its request fields stable until its valid is seen, and drops req the cycle after valid.
REQ-017 Requests arriving while not in IDLE SHALL be held pending and not lost (level-sensitive).
REQ-018 Minimum latency SHALL be 3 cycles, from req sampled in IDLE to valid: IDLE, then BUSY with mready, then DONE.
REQ-019 irdata and drdata SHALL hold their last captured value until the next completion on that port.
REQ-020 For data writes (dwe=1), dvalid SHALL still pulse, and drdata SHALL capture mrdata (content don't-care).
REQ-021 mwdata and mamp SHALL be 0 and 4'b1111 respectively for fetch transactions.

Configuration
REQ-022 Without XG_MEM_ARB_RR_EN, a conflict in IDLE SHALL always be granted to data (fixed priority, data > fetch).
REQ-023 With XG_MEM_ARB_RR_EN, SHALL keep a 1-bit last_grant register, updated on every grant.
REQ-024 With XG_MEM_ARB_RR_EN, a conflict SHALL be granted to the port not equal to last_grant.
REQ-025 last_grant SHALL reset to fetch, so the first conflict after reset goes to data in both builds.

Reset
REQ-026 reset=1 SHALL immediately force state to IDLE, mreq=0, mwe=0, ivalid=0 and dvalid=0.
REQ-027 reset=1 SHALL immediately clear maddr, mwdata, irdata and drdata to 0, set mamp to 4'b0000, and set last_grant to fetch.
REQ-028 Reset mid-transaction SHALL abandon it with no valid pulse; the memory sees mreq drop asynchronously.
REQ-029 After reset deassertion, the first grant SHALL occur no earlier than the next rising edge.

Verification
REQ-030 Fetch only: ireq=1, iaddr=0x100, mready high in first mreq cycle, mrdata=0x00500093 -> maddr=0x100, mwe=0; ivalid pulses at cycle 3; irdata=0x00500093.
REQ-031 Data write: dreq=1, dwe=1, damp=4'b0011, daddr=0x2004, dwdata=0xBEEF; mready delayed 4 cycles -> mreq held 5 cycles with fields stable; dvalid at cycle 7.
REQ-032 Conflict, fixed build: ireq and dreq high in the same cycle -> data served first, then fetch; two valid pulses, D before I, with an IDLE cycle between.
REQ-033 Conflict, XG_MEM_ARB_RR_EN: three back-to-back conflicts -> grant order D, I, D (then I, D, I... continuing by alternation).
REQ-034 Reset mid-op: assert reset while in DBUSY -> mreq=0 in the same cycle; no dvalid; a fresh dreq after release completes normally.
REQ-035 Pending hold: dreq rises while a fetch is in IBUSY -> data is granted in the IDLE cycle after DONE; ivalid and dvalid are never high together.
